// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder
//   AHB-Lite responder backed by a word-organised on-chip SRAM.
//   Serves the CPU instruction/data path behind the FreeAHB master with
//   optional wait states, byte/halfword/word little-endian lanes and a
//   two-cycle ERROR response for illegal accesses.
//
// Ports
//   i_hclk       clock, all state updates on the rising edge
//   i_hreset_n   asynchronous active-low reset
//   i_hsel       slave select
//   i_haddr      address-phase byte address
//   i_htrans     IDLE/BUSY/NONSEQ/SEQ
//   i_hwrite     1 = write
//   i_hsize      0 byte, 1 halfword, 2 word
//   i_hburst     ignored, every beat is decoded on its own
//   i_hwdata     data-phase write data
//   i_hready     bus-level ready (previous data phase ends when high)
//   o_hreadyout  this slave's ready
//   o_hresp      00 OKAY, 01 ERROR
//   o_hrdata     read data, valid on the final read data-phase cycle
module ahb_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        i_hclk,
  input  logic        i_hreset_n,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [2:0]  i_hburst,
  input  logic [31:0] i_hwdata,
  input  logic        i_hready,
  output logic        o_hreadyout,
  output logic [1:0]  o_hresp,
  output logic [31:0] o_hrdata
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES  = 32'(4 * DEPTH_WORDS);
  localparam int          WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WAIT_LOAD   = WAIT_LOAD_I[3:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg;
  logic [1:0]       lane_reg;
  logic [2:0]       size_reg;
  logic             write_reg;
  logic [3:0]       fwd_be_reg;
  logic [31:0]      fwd_data_reg;
  logic [31:0]      hold_reg;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      rd_q;
  logic [31:0]      read_word;

  // Burst type and the low htrans bit carry no information for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{i_hburst, i_htrans[0]};

  // ---------------------------------------------------------------------
  // Address decode and legality of the current address phase
  // ---------------------------------------------------------------------
  logic [31:0]      offset;
  logic [IDX_W-1:0] addr_idx;
  logic             align_ok;
  logic             legal;
  logic             accept_window;
  logic             accept;

  assign offset   = i_haddr - ADDR_BASE;
  assign addr_idx = offset[IDX_W+1:2];

  always_comb begin
    align_ok = 1'b0;
    case (i_hsize)
      3'd0:    align_ok = 1'b1;
      3'd1:    align_ok = ~i_haddr[0];
      3'd2:    align_ok = (i_haddr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign legal = (offset < SPAN_BYTES) && (i_hsize <= 3'd2) && align_ok;

  // Address phases can only complete while this slave is not stalling.
  assign accept_window = (state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                         (state_reg == ST_ERR2);
  assign accept = i_hsel & i_hready & i_htrans[1] & accept_window;

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) begin
          if (!legal) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // SRAM write / read control
  // ---------------------------------------------------------------------
  logic             wr_en;
  logic [3:0]       wr_be;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             fwd_hit;

  always_comb begin
    wr_be = 4'b1111;
    case (size_reg)
      3'd0:    wr_be = 4'b0001 << lane_reg;
      3'd1:    wr_be = 4'b0011 << lane_reg;
      default: wr_be = 4'b1111;
    endcase
  end

  assign wr_en = (state_reg == ST_DONE) && write_reg;

  // The SRAM is read on the edge that enters the read DONE cycle: straight
  // from the bus address when there are no wait states, otherwise from the
  // latched index on the last WAIT cycle.
  assign rd_en  = (accept && legal && !i_hwrite && (WAIT_STATES == 0)) ||
                  ((state_reg == ST_WAIT) && (cnt_reg == 4'd0) && !write_reg);
  assign rd_idx = (state_reg == ST_WAIT) ? idx_reg : addr_idx;

  // A write committing on the same edge the SRAM is read is invisible to the
  // read port, so its bytes are captured and merged into the read data.
  assign fwd_hit = wr_en && (rd_idx == idx_reg);

  always_ff @(posedge i_hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) begin
        mem[idx_reg][8*b +: 8] <= i_hwdata[8*b +: 8];
      end
    end
    if (rd_en) begin
      rd_q <= mem[rd_idx];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_merge
    assign read_word[8*gi +: 8] = fwd_be_reg[gi] ? fwd_data_reg[8*gi +: 8]
                                                 : rd_q[8*gi +: 8];
  end

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      lane_reg     <= 2'd0;
      size_reg     <= 3'd0;
      write_reg    <= 1'b0;
      fwd_be_reg   <= 4'd0;
      fwd_data_reg <= 32'd0;
      hold_reg     <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg   <= addr_idx;
        lane_reg  <= i_haddr[1:0];
        size_reg  <= i_hsize;
        write_reg <= i_hwrite;
      end
      if (rd_en) begin
        fwd_be_reg   <= fwd_hit ? wr_be : 4'd0;
        fwd_data_reg <= i_hwdata;
      end
      // Keep the last returned word on the bus between reads.
      if ((state_reg == ST_DONE) && !write_reg) begin
        hold_reg <= read_word;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_hreadyout = !((state_reg == ST_WAIT) || (state_reg == ST_ERR1));
  assign o_hresp     = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? 2'b01 : 2'b00;
  assign o_hrdata    = ((state_reg == ST_DONE) && !write_reg) ? read_word : hold_reg;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: one instance with no wait states and one
// with three, each driven by its own master task and checked against a
// byte-level memory model derived from the address/lane rules.
module tb_ahb_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [2];
  logic        hsel     [2];
  logic [31:0] haddr    [2];
  logic [1:0]  htrans   [2];
  logic        hwrite   [2];
  logic [2:0]  hsize    [2];
  logic [2:0]  hburst   [2];
  logic [31:0] hwdata   [2];
  logic        hready   [2];
  logic        readyout [2];
  logic [1:0]  hresp    [2];
  logic [31:0] hrdata   [2];

  assign hready[0] = readyout[0];
  assign hready[1] = readyout[1];

  ahb_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
    .i_hclk(clk), .i_hreset_n(rst_n[0]), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
    .i_htrans(htrans[0]), .i_hwrite(hwrite[0]), .i_hsize(hsize[0]), .i_hburst(hburst[0]),
    .i_hwdata(hwdata[0]), .i_hready(hready[0]), .o_hreadyout(readyout[0]),
    .o_hresp(hresp[0]), .o_hrdata(hrdata[0])
  );

  ahb_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
    .i_hclk(clk), .i_hreset_n(rst_n[1]), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
    .i_htrans(htrans[1]), .i_hwrite(hwrite[1]), .i_hsize(hsize[1]), .i_hburst(hburst[1]),
    .i_hwdata(hwdata[1]), .i_hready(hready[1]), .o_hreadyout(readyout[1]),
    .o_hresp(hresp[1]), .o_hrdata(hrdata[1])
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: memory image plus which bytes are known.
  logic [31:0] model_mem [2][1024];
  logic [3:0]  known     [2][1024];

  // Transfer table for one pipelined group.
  logic [31:0] t_addr  [8];
  logic        t_wr    [8];
  logic [2:0]  t_size  [8];
  logic [31:0] t_wdata [8];
  logic [1:0]  t_trans [8];
  logic [31:0] r_data  [8];
  int          r_cycles[8];
  logic [1:0]  r_resp0 [8];
  logic [1:0]  r_resp  [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] off;
    off = a - BASE;
    return (off < 32'd4096) && (s <= 3'd2) && ((a & ((32'd1 << s) - 32'd1)) == 32'd0);
  endfunction

  task automatic set_t(input int k, input logic [31:0] a, input logic w,
                       input logic [2:0] s, input logic [31:0] wd, input logic [1:0] tr);
    t_addr[k] = a; t_wr[k] = w; t_size[k] = s; t_wdata[k] = wd; t_trans[k] = tr;
  endtask

  task automatic drive_addr(input int d, input int k, input int n);
    if (k < n) begin
      hsel[d] = 1'b1; haddr[d] = t_addr[k]; htrans[d] = t_trans[k];
      hwrite[d] = t_wr[k]; hsize[d] = t_size[k];
    end else begin
      hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = 2'b00;
      hwrite[d] = 1'b0; hsize[d] = 3'd0;
    end
  endtask

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd);
    logic [31:0] off;
    int idx, lane, nb;
    off  = a - BASE;
    idx  = int'(off[11:2]);
    lane = int'(a[1:0]);
    nb   = 1 << s;
    for (int b = 0; b < 4; b++) begin
      if (b >= lane && b < lane + nb) begin
        model_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
        known[d][idx][b] = 1'b1;
      end
    end
  endtask

  // Runs t_*[0..n-1] back to back on DUT d and checks every data phase.
  // Entered and left just after a rising edge with the bus idle.
  task automatic run(input int d, input int n, input string tag);
    bit          active, legal, done;
    int          cyc, exp_cyc, idx;
    logic [1:0]  exp_resp;
    logic [31:0] mask, off;
    drive_addr(d, 0, n);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      drive_addr(d, k + 1, n);
      hwdata[d] = t_wdata[k];
      active   = t_trans[k][1];
      legal    = is_legal(t_addr[k], t_size[k]);
      exp_cyc  = !active ? 1 : (legal ? ws_of(d) + 1 : 2);
      exp_resp = (active && !legal) ? 2'b01 : 2'b00;
      cyc  = 0;
      done = 0;
      while (!done && cyc < 40) begin
        @(negedge clk);
        cyc = cyc + 1;
        if (cyc == 1) r_resp0[k] = hresp[d];
        if (readyout[d]) begin
          done        = 1;
          r_data[k]   = hrdata[d];
          r_resp[k]   = hresp[d];
          r_cycles[k] = cyc;
        end else begin
          check($sformatf("%s[%0d].wait_resp", tag, k), {30'd0, hresp[d]}, {30'd0, exp_resp});
        end
        @(posedge clk); #1;
      end
      if (!done) begin
        r_cycles[k] = cyc;
        check($sformatf("%s[%0d].timeout", tag, k), 32'd1, 32'd0);
      end
      check($sformatf("%s[%0d].cycles", tag, k), 32'(cyc), 32'(exp_cyc));
      check($sformatf("%s[%0d].resp", tag, k), {30'd0, r_resp[k]}, {30'd0, exp_resp});
      if (active && legal) begin
        off = t_addr[k] - BASE;
        idx = int'(off[11:2]);
        if (t_wr[k]) begin
          model_write(d, t_addr[k], t_size[k], t_wdata[k]);
        end else begin
          for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{known[d][idx][b]}};
          if (mask != 32'd0)
            check($sformatf("%s[%0d].rdata", tag, k), r_data[k] & mask, model_mem[d][idx] & mask);
        end
      end
      $display("%s[%0d] dut=%0d addr=%08h wr=%0d size=%0d trans=%0d cyc=%0d resp=%0d rdata=%08h",
               tag, k, d, t_addr[k], t_wr[k], t_size[k], t_trans[k], cyc, r_resp[k], r_data[k]);
    end
  endtask

  task automatic random_group(input int d, input int g);
    int n, w, r, r2;
    logic [2:0]  s;
    logic [31:0] a;
    logic [1:0]  tr;
    n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) begin
      w  = $urandom_range(0, 15);
      r  = $urandom_range(0, 99);
      s  = (r < 5) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = BASE + 32'(w * 4);
      if (s == 3'd0) a = a + 32'($urandom_range(0, 3));
      else if (s == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
      r2 = $urandom_range(0, 99);
      if (r2 < 8) a = BASE + 32'h1000 + 32'(w * 4);
      else if (r2 < 12) a = 32'h7FFF_FFF0;
      else if (r2 < 20) a = a | 32'd1;
      r  = $urandom_range(0, 9);
      tr = (r < 7) ? 2'b10 : (r == 7) ? 2'b11 : (r == 8) ? 2'b00 : 2'b01;
      set_t(k, a, 1'($urandom_range(0, 1)), s, $urandom, tr);
    end
    hburst[d] = 3'($urandom_range(0, 7));
    run(d, n, $sformatf("rnd%0d_%0d", d, g));
    hburst[d] = 3'd0;
  endtask

  localparam logic [1:0] NSQ = 2'b10;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = 2'b00;
      hwrite[d] = 1'b0; hsize[d] = 3'd0; hburst[d] = 3'd0; hwdata[d] = 32'd0;
      for (int i = 0; i < 1024; i++) begin
        known[d][i] = 4'd0;
        model_mem[d][i] = 32'd0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset.ready%0d", d), {31'd0, readyout[d]}, 32'd1);
      check($sformatf("reset.resp%0d", d), {30'd0, hresp[d]}, 32'd0);
      check($sformatf("reset.rdata%0d", d), hrdata[d], 32'd0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // 1: zero-wait word write and read-back
    set_t(0, 32'h8000_0000, 1'b1, 3'd2, 32'hF0FF_0FAA, NSQ); run(0, 1, "t1_wr");
    set_t(0, 32'h8000_0000, 1'b0, 3'd2, 32'd0, NSQ);         run(0, 1, "t1_rd");
    check("t1.data", r_data[0], 32'hF0FF_0FAA);
    check("t1.latency", 32'(r_cycles[0]), 32'd1);

    // 2: byte and halfword lanes
    set_t(0, 32'h8000_0002, 1'b1, 3'd0, 32'h0055_0000, NSQ); run(0, 1, "t2_wb");
    set_t(0, 32'h8000_0000, 1'b0, 3'd2, 32'd0, NSQ);         run(0, 1, "t2_rb");
    check("t2.byte", r_data[0], 32'hF055_0FAA);
    set_t(0, 32'h8000_0000, 1'b1, 3'd1, 32'h0000_1234, NSQ); run(0, 1, "t2_wh");
    set_t(0, 32'h8000_0000, 1'b0, 3'd2, 32'd0, NSQ);         run(0, 1, "t2_rh");
    check("t2.half", r_data[0], 32'hF055_1234);

    // 3: three wait states
    set_t(0, 32'h8000_0000, 1'b1, 3'd2, 32'h0BAD_F00D, NSQ); run(1, 1, "t3_w0");
    set_t(0, 32'h8000_0000, 1'b0, 3'd2, 32'd0, NSQ);         run(1, 1, "t3_r0");
    check("t3.read_cycles", 32'(r_cycles[0]), 32'd4);
    check("t3.read_data", r_data[0], 32'h0BAD_F00D);
    set_t(0, 32'h8000_0004, 1'b1, 3'd2, 32'hA1A1_A1A1, NSQ);
    set_t(1, 32'h8000_0008, 1'b1, 3'd2, 32'hB2B2_B2B2, NSQ); run(1, 2, "t3_wb2b");
    check("t3.wr0_cycles", 32'(r_cycles[0]), 32'd4);
    check("t3.wr1_cycles", 32'(r_cycles[1]), 32'd4);
    set_t(0, 32'h8000_0004, 1'b0, 3'd2, 32'd0, NSQ);
    set_t(1, 32'h8000_0008, 1'b0, 3'd2, 32'd0, NSQ);         run(1, 2, "t3_rb2b");
    check("t3.rd0", r_data[0], 32'hA1A1_A1A1);
    check("t3.rd1", r_data[1], 32'hB2B2_B2B2);

    // 4: ERROR responses
    set_t(0, 32'h8000_1000, 1'b0, 3'd2, 32'd0, NSQ);         run(0, 1, "t4_range");
    check("t4.range_resp0", {30'd0, r_resp0[0]}, 32'd1);
    set_t(0, 32'h8000_0002, 1'b1, 3'd2, 32'hFFFF_FFFF, NSQ); run(0, 1, "t4_align");
    check("t4.align_cycles", 32'(r_cycles[0]), 32'd2);
    set_t(0, 32'h8000_0000, 1'b1, 3'd3, 32'hEEEE_EEEE, NSQ); run(0, 1, "t4_size");
    check("t4.size_resp", {30'd0, r_resp[0]}, 32'd1);
    set_t(0, 32'h8000_0000, 1'b0, 3'd2, 32'd0, NSQ);         run(0, 1, "t4_rd");
    check("t4.unchanged", r_data[0], 32'hF055_1234);
    set_t(0, 32'h8000_1000, 1'b0, 3'd2, 32'd0, 2'b00);       run(0, 1, "t4_idle");
    check("t4.idle_resp", {30'd0, r_resp[0]}, 32'd0);
    check("t4.idle_cycles", 32'(r_cycles[0]), 32'd1);

    // 5: reset during the second WAIT cycle of a write
    set_t(0, 32'h8000_0010, 1'b1, 3'd2, 32'h1111_2222, NSQ); run(1, 1, "t5_pre");
    set_t(0, 32'h8000_0010, 1'b0, 3'd2, 32'd0, NSQ);         run(1, 1, "t5_prerd");
    set_t(0, 32'h8000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, NSQ);
    drive_addr(1, 0, 1);
    @(posedge clk); #1;
    drive_addr(1, 1, 1);
    hwdata[1] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("t5.in_wait", {31'd0, readyout[1]}, 32'd0);
    rst_n[1] = 1'b0;
    #1;
    check("t5.rst_ready", {31'd0, readyout[1]}, 32'd1);
    check("t5.rst_resp", {30'd0, hresp[1]}, 32'd0);
    check("t5.rst_rdata", hrdata[1], 32'd0);
    $display("t5 reset asserted mid-write: ready=%0d resp=%0d rdata=%08h", readyout[1], hresp[1], hrdata[1]);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    set_t(0, 32'h8000_0010, 1'b0, 3'd2, 32'd0, NSQ);         run(1, 1, "t5_post");
    check("t5.prior", r_data[0], 32'h1111_2222);

    // 6: pipelined write then read of the same word
    set_t(0, 32'h8000_0020, 1'b1, 3'd2, 32'hCAFE_0001, NSQ);
    set_t(1, 32'h8000_0020, 1'b0, 3'd2, 32'd0, NSQ);         run(0, 2, "t6_ws0");
    check("t6.ws0", r_data[1], 32'hCAFE_0001);
    set_t(0, 32'h8000_0020, 1'b1, 3'd2, 32'hCAFE_0003, NSQ);
    set_t(1, 32'h8000_0020, 1'b0, 3'd2, 32'd0, NSQ);         run(1, 2, "t6_ws3");
    check("t6.ws3", r_data[1], 32'hCAFE_0003);
    set_t(0, 32'h8000_0021, 1'b1, 3'd0, 32'h0000_7700, NSQ);
    set_t(1, 32'h8000_0020, 1'b0, 3'd2, 32'd0, NSQ);         run(0, 2, "t6_byte");
    check("t6.byte", r_data[1], 32'hCAFE_7701);

    // Randomized traffic on both instances
    for (int g = 0; g < 30; g++) begin
      random_group(0, g);
      random_group(1, g);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
